// File: rtl/console_rx_fifo_if.sv
// ============================================================================
// Module  : console_rx_fifo_if
// Purpose : UART-poll and CPU-pop signal bundle for the console receive FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface console_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [31:0]     uart_dat_do;
    logic            uart_dat_re;
    logic            pop;
    logic            flush;
    logic [31:0]     rdata;
    logic            rdata_valid;
    logic            empty;
    logic            full;
    logic [c_CW-1:0] count;
    logic            overflow;
    logic [7:0]      drop_count;

    modport slave (
        input  uart_dat_do, pop, flush,
        output uart_dat_re, rdata, rdata_valid, empty, full, count, overflow, drop_count
    );

    modport master (
        output uart_dat_do, pop, flush,
        input  uart_dat_re, rdata, rdata_valid, empty, full, count, overflow, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/console_rx_fifo.sv
// ============================================================================
// Module  : console_rx_fifo
// Purpose : Polls the UART data register into a byte FIFO popped by the CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module console_rx_fifo #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] NODATA = 32'hFFFF_FFFF
) (
    input  wire logic            CLK,
    input  wire logic            rst,
    console_rx_fifo_if.slave     bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        POLL   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_rdata;
    logic            r_rdata_valid;
    logic            r_overflow;
    logic [7:0]      r_drop_count;

    logic w_req;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;

    always_ff @(posedge CLK) begin
        if (rst) r_state <= POLL;
        else     r_state <= w_state_next;
    end

    // SETTLE blanks one cycle while the UART drops its stale valid data
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            POLL: begin
                if (bus.uart_dat_do != NODATA) begin
                    w_req        = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK:     w_state_next = SETTLE;
            SETTLE:  w_state_next = POLL;
            default: w_state_next = POLL;
        endcase
    end

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_req && !w_full && !bus.flush;
    assign w_drop  = w_req && w_full;
    assign w_pop   = bus.pop && !w_empty;

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= bus.uart_dat_do[7:0];
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_count  <= '0;
        end else if (bus.flush) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_rdata_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_count  <= '0;
            if (bus.pop) r_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop) begin
                r_rptr        <= r_rptr + c_AW'(1);
                r_rdata       <= {24'b0, r_mem[r_rptr]};
                r_rdata_valid <= 1'b1;
            end else begin
                r_rdata_valid <= 1'b0;
                if (bus.pop) r_rdata <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.uart_dat_re = (r_state == ACK);
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_count;
endmodule

`default_nettype wire

// File: tb/tb_console_rx_fifo.sv
// ============================================================================
// Module  : tb_console_rx_fifo
// Purpose : Directed plus randomized check of console_rx_fifo against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_console_rx_fifo;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] NODATA = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    console_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    console_rx_fifo #(.DEPTH(DEPTH), .NODATA(NODATA)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        manual   = 1'b1;
    logic [31:0] man_val  = NODATA;
    logic [31:0] auto_val = NODATA;
    logic        pop_r    = 1'b0;
    logic        flush_r  = 1'b0;
    logic        fast     = 1'b1;

    assign bus.uart_dat_do = manual ? man_val : auto_val;
    assign bus.pop         = pop_r;
    assign bus.flush       = flush_r;

    int checks = 0;
    int errors = 0;
    int re_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // UART stand-in: holds a byte until it sees the read pulse, keeps it one
    // extra cycle (stale data), then moves on.
    logic [7:0] txq[$];
    logic       uart_hold = 1'b0;
    logic       stale     = 1'b0;

    always @(posedge clk) begin
        logic        re_s;
        logic [31:0] tmp;
        re_s = bus.uart_dat_re;
        #1;
        if (!manual) begin
            if (uart_hold) begin
                if (stale) begin
                    stale     = 1'b0;
                    uart_hold = 1'b0;
                    auto_val  = NODATA;
                end else if (re_s) begin
                    stale = 1'b1;
                end
            end
            if (!uart_hold && txq.size() > 0 && (fast || $urandom_range(0, 3) != 0)) begin
                tmp       = $urandom();
                auto_val  = {1'b0, tmp[30:8], txq.pop_front()};
                uart_hold = 1'b1;
            end
        end
    end

    // Behavioural model: a byte queue plus the capture cadence (one capture,
    // then the read-pulse cycle, then a blind cycle).
    logic [7:0]  mq[$];
    logic        m_ovf    = 1'b0;
    int          m_drops  = 0;
    logic [31:0] m_rdata  = '0;
    logic        m_rv     = 1'b0;
    int          m_phase  = 0;
    logic        model_on = 1'b0;

    always @(posedge clk) begin
        logic req;
        logic was_full;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            m_rdata = '0;
            m_rv    = 1'b0;
            m_phase = 0;
        end else begin
            req      = (m_phase == 0) && (bus.uart_dat_do != NODATA);
            was_full = (mq.size() == DEPTH);
            if (req)               m_phase = 1;
            else if (m_phase == 1) m_phase = 2;
            else                   m_phase = 0;
            if (flush_r) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
                m_rv    = 1'b0;
                if (pop_r) m_rdata = '0;
            end else begin
                if (pop_r) begin
                    if (mq.size() > 0) begin
                        m_rdata = {24'b0, mq.pop_front()};
                        m_rv    = 1'b1;
                    end else begin
                        m_rdata = '0;
                        m_rv    = 1'b0;
                    end
                end else begin
                    m_rv = 1'b0;
                end
                if (req) begin
                    if (!was_full) mq.push_back(bus.uart_dat_do[7:0]);
                    else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.uart_dat_re) re_pulses++;
        if (model_on) begin
            chk("cyc_count",    32'(bus.count),       32'(mq.size()));
            chk("cyc_empty",    32'(bus.empty),       32'(mq.size() == 0));
            chk("cyc_full",     32'(bus.full),        32'(mq.size() == DEPTH));
            chk("cyc_rdata",    bus.rdata,            m_rdata);
            chk("cyc_rvalid",   32'(bus.rdata_valid), 32'(m_rv));
            chk("cyc_overflow", 32'(bus.overflow),    32'(m_ovf));
            chk("cyc_drops",    32'(bus.drop_count),  32'(m_drops));
            chk("cyc_re",       32'(bus.uart_dat_re), 32'(m_phase == 1));
        end
    end

    task automatic do_pop();
        pop_r = 1'b1;
        step();
        pop_r = 1'b0;
    endtask

    task automatic wait_re(input string name);
        int n = 0;
        while (!bus.uart_dat_re && n < 50) begin
            step();
            n++;
        end
        if (!bus.uart_dat_re) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((txq.size() != 0 || uart_hold) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) timeout_fail(name);
        repeat (4) step();
    endtask

    initial begin
        int base;
        repeat (3) step();
        rst      = 1'b0;
        model_on = 1'b1;

        chk("rst_empty",    32'(bus.empty),       32'd1);
        chk("rst_full",     32'(bus.full),        32'd0);
        chk("rst_count",    32'(bus.count),       32'd0);
        chk("rst_rdata",    bus.rdata,            32'd0);
        chk("rst_re",       32'(bus.uart_dat_re), 32'd0);
        chk("rst_overflow", 32'(bus.overflow),    32'd0);

        do_pop();
        chk("pop_empty_rdata",  bus.rdata,            32'd0);
        chk("pop_empty_rvalid", 32'(bus.rdata_valid), 32'd0);

        base    = re_pulses;
        man_val = 32'h41;
        wait_re("wait_re_41");
        man_val = NODATA;
        repeat (4) step();
        chk("byte41_pulses", 32'(re_pulses - base), 32'd1);
        chk("byte41_count",  32'(bus.count),        32'd1);
        do_pop();
        chk("byte41_rdata",  bus.rdata,            32'h41);
        chk("byte41_rvalid", 32'(bus.rdata_valid), 32'd1);
        chk("byte41_empty",  32'(bus.empty),       32'd1);

        manual = 1'b0;
        for (int i = 1; i <= DEPTH; i++) txq.push_back(8'(i));
        wait_idle("fill16");
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        txq.push_back(8'hAA);
        wait_idle("push_aa");
        chk("aa_overflow", 32'(bus.overflow),   32'd1);
        chk("aa_drops",    32'(bus.drop_count), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            do_pop();
            chk("drain_order", bus.rdata, 32'(i));
        end
        step();
        chk("drain_empty", 32'(bus.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) txq.push_back(8'(8'h10 + i));
        wait_idle("fill10");
        manual  = 1'b1;
        man_val = NODATA;
        step();
        man_val = 32'h55;
        pop_r   = 1'b1;
        step();
        pop_r   = 1'b0;
        man_val = NODATA;
        chk("fullpop_rdata",  bus.rdata,            32'h10);
        chk("fullpop_rvalid", 32'(bus.rdata_valid), 32'd1);
        repeat (4) step();
        chk("fullpop_count", 32'(bus.count),      32'd15);
        chk("fullpop_drops", 32'(bus.drop_count), 32'd2);

        manual = 1'b0;
        txq.push_back(8'h20);
        wait_idle("refill");
        chk("refill_count", 32'(bus.count), 32'd16);
        manual  = 1'b1;
        man_val = 32'h77;
        repeat (915) step();
        man_val = NODATA;
        repeat (4) step();
        chk("sat_drops",    32'(bus.drop_count), 32'd255);
        chk("sat_overflow", 32'(bus.overflow),   32'd1);
        flush_r = 1'b1;
        step();
        flush_r = 1'b0;
        chk("flush_count",    32'(bus.count),       32'd0);
        chk("flush_overflow", 32'(bus.overflow),    32'd0);
        chk("flush_drops",    32'(bus.drop_count),  32'd0);
        chk("flush_rvalid",   32'(bus.rdata_valid), 32'd0);

        man_val = 32'hC3;
        wait_re("wait_re_c3");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ackrst_re",    32'(bus.uart_dat_re), 32'd0);
        chk("ackrst_count", 32'(bus.count),       32'd0);
        wait_re("wait_re_c3_again");
        man_val = NODATA;
        repeat (4) step();
        chk("ackrst_recapture", 32'(bus.count), 32'd1);
        do_pop();
        chk("ackrst_rdata", bus.rdata, 32'hC3);

        manual = 1'b0;
        fast   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (txq.size() < 4) txq.push_back(8'($urandom()));
            pop_r   = ($urandom_range(0, (cyc < 1500) ? 7 : 1) == 0);
            flush_r = ($urandom_range(0, 299) == 0);
            step();
        end
        pop_r   = 1'b0;
        flush_r = 1'b0;
        txq.delete();
        wait_idle("random_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        timeout_fail("global");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/console_rx_fifo.md
# console_rx_fifo

Receive-side buffer between the `simpleuart` console and the CPU core. It polls the UART data register, captures each received byte into a DEPTH-entry FIFO, and acknowledges the UART with a one-cycle read pulse. The CPU pops bytes at its own pace. An empty FIFO returns 0, which preserves the core's existing "0 means no character" convention for the non-blocking console read. Overflow is recorded instead of silently lost.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- NODATA, 32'hFFFFFFFF, value `uart_dat_do` presents when the UART holds no received byte

Ports:
- CLK  in  1  system clock (16 MHz); all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- uart_dat_do  in  32  UART data register output; byte in [7:0] when != NODATA
- uart_dat_re  out  1  one-cycle read/acknowledge pulse to UART `reg_dat_re`
- pop  in  1  CPU pop request, single-cycle strobe
- flush  in  1  synchronous clear of FIFO contents and status
- rdata  out  32  popped byte zero-extended; 0 when popped while empty
- rdata_valid  out  1  high one cycle when rdata carries a real byte
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a byte was discarded because FIFO was full
- drop_count  out  8  discarded-byte counter, saturates at 255

## Operation
- Storage: DEPTH x 8 array with write pointer and read pointer of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH. Occupancy is tracked by `count`.
- Poll FSM, three states:
  - POLL: if `uart_dat_do != NODATA`, then:
    - if not full, write `uart_dat_do[7:0]` at wptr and advance wptr;
    - if full, discard the byte, set overflow, and increment drop_count (saturating).
    - In both cases set uart_dat_re <= 1 and go to ACK. Otherwise stay in POLL.
  - ACK: uart_dat_re <= 0; go to SETTLE.
  - SETTLE: ignore uart_dat_do, because the UART is still clearing its valid flag; go to POLL.
- The full test uses `count` before any same-cycle pop. A push while full is dropped even if pop is asserted in the same cycle.
- Pop:
  - When not empty: rdata <= {24'b0, mem[rptr]}, rdata_valid <= 1, and rptr advances.
  - When empty: rdata <= 0, rdata_valid <= 0, and no state changes.
  - When pop is low: rdata holds its value and rdata_valid <= 0.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Pop while empty with a same-cycle push: there is no bypass; pop returns 0 and the pushed byte remains queued.
- Flush sets pointers, count, overflow, and drop_count to 0, and sets rdata_valid to 0.
  - Flush overrides a same-cycle push (byte lost, not counted as a drop) and a same-cycle pop (rdata <= 0).
  - The FSM is not reset by flush; an in-progress ACK/SETTLE completes normally.
- Reset: FSM goes to POLL, uart_dat_re = 0, pointers/count = 0, rdata = 0, rdata_valid = 0, overflow = 0, drop_count = 0. Consequently empty = 1 and full = 0. Memory contents are not cleared.
  - Reset asserted mid-handshake (ACK) drops uart_dat_re at that edge. The UART may then re-present the same byte, which is captured again after reset. This is acceptable.

## Timing
- Capture: the byte is valid on uart_dat_do in cycle T (state POLL). The entry is written and count is updated at the end of T. uart_dat_re is high during T+1. The FSM is back in POLL at T+3.
- Maximum capture rate is one byte per 3 cycles, far above any supported baud.
- Pop: pop high in cycle N gives rdata/rdata_valid visible in cycle N+1. count decrements visible in N+1.
- empty/full/count are combinational from registered count. No added latency.
- uart_dat_re is never high for more than one consecutive cycle.

## Test plan
- After reset: empty=1, full=0, count=0, rdata=0, uart_dat_re=0, overflow=0. Pop while empty -> rdata=0, rdata_valid=0.
- UART presents 8'h41 and clears after the re pulse -> exactly one uart_dat_re pulse, count=1. Pop -> rdata=32'h41, rdata_valid=1, empty=1.
- Push bytes 1..16 (DEPTH=16) -> full=1, count=16. 17th byte 8'hAA -> re pulsed, overflow=1, drop_count=1. Pop 16 times -> values 1..16 in order; pointers wrap correctly.
- At full, push 8'h55 with a same-cycle pop -> pop returns oldest byte, 8'h55 dropped, count=15, drop_count increments.
- 300 drops while full -> drop_count saturates at 255. Flush -> count=0, overflow=0, drop_count=0, rdata_valid=0.
- Assert rst during ACK -> uart_dat_re low next cycle, count=0. The UART re-presents the byte -> it is captured once after reset.
